// File: rtl/serial_receiver_8x_pkg.sv
// ----------------------------------------------------------------------------
// serial_receiver_8x_pkg
// Shared definitions for the oversampling serial receiver:
//   - default oversample ratio and payload width
//   - receiver FSM state encoding
//   - mid-bit sample offset (cycles from the start-bit edge to the first
//     sample instant)
// ----------------------------------------------------------------------------
package serial_receiver_8x_pkg;

    localparam int OVERSAMPLE_DEFAULT = 8;
    localparam int DATA_BITS_DEFAULT  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Cycles after the detected falling edge at which the middle of a bit
    // is reached. The edge cycle itself counts as cycle 0.
    function automatic int mid_offset(input int oversample);
        return oversample / 2 - 1;
    endfunction

    localparam int MID_OFFSET_DEFAULT = mid_offset(OVERSAMPLE_DEFAULT);

endpackage

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level. Both flops reset
// to RESET_VALUE so an idle-high line does not show a false edge on release.
// Ports:
//   clock  - destination clock
//   reset  - asynchronous active-low reset
//   d      - asynchronous input
//   q      - synchronized output
// ----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_receiver_8x.sv
// ----------------------------------------------------------------------------
// serial_receiver_8x
// Oversampling asynchronous serial receiver. Frame: start bit (0), DATA_BITS
// payload bits LSB first, stop bit (1). Each bit lasts OVERSAMPLE clocks and
// is sampled once at its middle, timed from the first low cycle of rx_sync.
// Ports:
//   clock       - system clock, all logic on the rising edge
//   reset       - asynchronous active-low reset
//   rx_in       - serial line, idles high, asynchronous to clock
//   data_out    - payload of the last correctly framed character
//   data_valid  - one-cycle pulse when data_out is updated
//   frame_error - one-cycle pulse when a stop bit samples low
//   busy        - high whenever the FSM is not in IDLE
//   fsm_state   - current FSM state, for observation only
// Handshake: data_valid and frame_error are unqualified one-cycle pulses;
// there is no ready/backpressure, a consumer must capture data_out in the
// cycle data_valid is high (data_out then holds until the next good frame).
// ----------------------------------------------------------------------------
module serial_receiver_8x
    import serial_receiver_8x_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int DATA_BITS  = DATA_BITS_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 busy,
    output rx_state_t            fsm_state
);

    localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(mid_offset(OVERSAMPLE));
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    logic rx_sync;

    rx_state_t            state_q, state_next;
    logic [CNT_W-1:0]     sample_cnt, sample_cnt_next;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [DATA_BITS-1:0] data_next;
    logic                 valid_next;
    logic                 error_next;
    // Cleared by a framing error so a line stuck low cannot start a new
    // frame; set again by any high cycle on rx_sync.
    logic                 armed, armed_next;
    logic                 sample_tick;

    sync_2ff #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx_in),
        .q     (rx_sync)
    );

    // sample_cnt holds (cycles since the edge) mod OVERSAMPLE, so the
    // mid-bit instants are simply the cycles where it equals MID_CNT.
    assign sample_tick = (sample_cnt == MID_CNT);

    always_comb begin
        state_next      = state_q;
        sample_cnt_next = sample_cnt;
        bit_cnt_next    = bit_cnt;
        shift_next      = shift_reg;
        data_next       = data_out;
        valid_next      = 1'b0;
        error_next      = 1'b0;
        armed_next      = armed;

        if (state_q != IDLE) begin
            sample_cnt_next = (sample_cnt == CNT_LAST) ? '0 : sample_cnt + CNT_ONE;
        end

        case (state_q)
            IDLE: begin
                sample_cnt_next = '0;
                bit_cnt_next    = '0;
                if (rx_sync) begin
                    armed_next = 1'b1;
                end else if (armed) begin
                    // This cycle is the edge cycle (count 0); the next is 1.
                    state_next      = START;
                    sample_cnt_next = CNT_ONE;
                end
            end

            START: begin
                if (sample_tick) begin
                    if (rx_sync) begin
                        // Start bit did not survive to mid-bit: a glitch.
                        state_next      = IDLE;
                        sample_cnt_next = '0;
                    end else begin
                        state_next = DATA;
                    end
                end
            end

            DATA: begin
                if (sample_tick) begin
                    // LSB arrives first, so shifting in at the MSB end leaves
                    // the payload in natural order after the last bit.
                    shift_next                = shift_reg >> 1;
                    shift_next[DATA_BITS-1]   = rx_sync;
                    if (bit_cnt == BIT_LAST) begin
                        state_next   = STOP;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + BIT_ONE;
                    end
                end
            end

            STOP: begin
                if (sample_tick) begin
                    // Leave at mid-stop so a back-to-back start edge, half a
                    // bit later, is seen from IDLE.
                    state_next      = IDLE;
                    sample_cnt_next = '0;
                    if (rx_sync) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                    end else begin
                        error_next = 1'b1;
                        armed_next = 1'b0;
                    end
                end
            end

            default: begin
                state_next      = IDLE;
                sample_cnt_next = '0;
                bit_cnt_next    = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sample_cnt  <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            armed       <= 1'b1;
        end else begin
            state_q     <= state_next;
            sample_cnt  <= sample_cnt_next;
            bit_cnt     <= bit_cnt_next;
            shift_reg   <= shift_next;
            data_out    <= data_next;
            data_valid  <= valid_next;
            frame_error <= error_next;
            armed       <= armed_next;
        end
    end

    assign busy      = (state_q != IDLE);
    assign fsm_state = state_q;

endmodule

// File: tb/tb_serial_receiver_8x.sv
// ----------------------------------------------------------------------------
// tb_serial_receiver_8x
// Drives serial frames into serial_receiver_8x and checks the received
// payloads, pulse timing and reset behaviour against a queue of expected
// payloads built from the frames the bench itself transmits.
// ----------------------------------------------------------------------------
module tb_serial_receiver_8x;
    import serial_receiver_8x_pkg::*;

    localparam int OS = 8;
    localparam int DB = 8;

    logic          clock;
    logic          reset;
    logic          rx_in;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          frame_error;
    logic          busy;
    rx_state_t     fsm_state;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int valid_cnt    = 0;
    int error_cnt    = 0;

    logic [DB-1:0] exp_q[$];
    int            valid_cyc_q[$];

    typedef struct {
        logic [DB-1:0] payload;
        logic          stop_bit;
        int            idle_bits;
        int            exp_valid;
        int            exp_error;
        logic [DB-1:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    serial_receiver_8x #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_in       (rx_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_error (frame_error),
        .busy        (busy),
        .fsm_state   (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clock) begin
        if (data_valid || frame_error)
            check("pulse_exclusive", {31'd0, data_valid & frame_error}, 32'd0);
        if (data_valid) begin
            valid_cnt++;
            valid_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_valid: data_out 0x%0h with no frame expected", data_out);
            end else begin
                check("sb_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
            end
        end
        if (frame_error) error_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic drive_bit(input logic b);
        repeat (OS) begin
            @(negedge clock);
            rx_in = b;
        end
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit, input int idle_bits);
        repeat (idle_bits) drive_bit(1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
    endtask

    // ---------------- test ----------------
    initial begin
        int v0, e0, q0, gap, rnd_cycles;
        logic saw_busy;
        logic [DB-1:0] rnd;

        vecs[0] = '{8'hA5, 1'b1, 2, 1, 0, 8'hA5};
        vecs[1] = '{8'h55, 1'b0, 1, 0, 1, 8'hA5};  // bad stop: data_out keeps 0xA5
        vecs[2] = '{8'h00, 1'b1, 1, 1, 0, 8'h00};
        vecs[3] = '{8'hFF, 1'b1, 1, 1, 0, 8'hFF};
        vecs[4] = '{8'h5A, 1'b1, 0, 1, 0, 8'h5A};

        reset = 1'b0;
        rx_in = 1'b1;
        #12;
        check("reset_data_out",    {24'd0, data_out}, 32'd0);
        check("reset_data_valid",  {31'd0, data_valid}, 32'd0);
        check("reset_frame_error", {31'd0, frame_error}, 32'd0);
        check("reset_busy",        {31'd0, busy}, 32'd0);
        check("reset_state",       {30'd0, fsm_state}, {30'd0, IDLE});
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // Table-driven single frames.
        for (int i = 0; i < 5; i++) begin
            v0 = valid_cnt;
            e0 = error_cnt;
            if (vecs[i].exp_valid != 0) exp_q.push_back(vecs[i].payload);
            send_frame(vecs[i].payload, vecs[i].stop_bit, vecs[i].idle_bits);
            drive_bit(1'b1);
            check($sformatf("vec%0d_valid_cnt", i), valid_cnt - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d_error_cnt", i), error_cnt - e0, vecs[i].exp_error);
            check($sformatf("vec%0d_data_out", i), {24'd0, data_out}, {24'd0, vecs[i].exp_data});
            check($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
        end

        // Back-to-back frames with no idle between them.
        q0 = valid_cyc_q.size();
        v0 = valid_cnt;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        send_frame(8'h3C, 1'b1, 1);
        send_frame(8'hC3, 1'b1, 0);
        drive_bit(1'b1);
        check("b2b_valid_cnt", valid_cnt - v0, 32'd2);
        gap = (valid_cyc_q.size() >= q0 + 2) ? valid_cyc_q[q0 + 1] - valid_cyc_q[q0] : 0;
        check("b2b_gap_cycles", gap, OS * (DB + 2));
        check("b2b_last_data", {24'd0, data_out}, 32'h0000_00C3);

        // Two-cycle low glitch on an idle line.
        v0 = valid_cnt;
        e0 = error_cnt;
        saw_busy = 1'b0;
        @(negedge clock); rx_in = 1'b0;
        @(negedge clock); rx_in = 1'b0;
        @(negedge clock); rx_in = 1'b1;
        repeat (3 * OS) begin
            @(negedge clock);
            saw_busy = saw_busy | busy;
        end
        check("glitch_saw_busy", {31'd0, saw_busy}, 32'd1);
        check("glitch_valid_cnt", valid_cnt - v0, 32'd0);
        check("glitch_error_cnt", error_cnt - e0, 32'd0);
        check("glitch_idle", {30'd0, fsm_state}, {30'd0, IDLE});

        // Reset pulse during bit 4 of 0xFF, then a clean 0x81.
        v0 = valid_cnt;
        e0 = error_cnt;
        drive_bit(1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        @(negedge clock); rx_in = 1'b1;
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("midreset_data_out",    {24'd0, data_out}, 32'd0);
        check("midreset_data_valid",  {31'd0, data_valid}, 32'd0);
        check("midreset_frame_error", {31'd0, frame_error}, 32'd0);
        check("midreset_busy",        {31'd0, busy}, 32'd0);
        #4 reset = 1'b1;
        saw_busy = 1'b0;
        repeat (5 * OS) begin
            @(negedge clock);
            rx_in = 1'b1;
            saw_busy = saw_busy | busy;
        end
        check("postreset_no_busy", {31'd0, saw_busy}, 32'd0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1);
        drive_bit(1'b1);
        check("postreset_valid_cnt", valid_cnt - v0, 32'd1);
        check("postreset_error_cnt", error_cnt - e0, 32'd0);
        check("postreset_data_out", {24'd0, data_out}, 32'h0000_0081);

        // Loopback: a divide-by-OS bit clock with random phase and gaps.
        v0 = valid_cnt;
        e0 = error_cnt;
        for (int f = 0; f < 20; f++) begin
            rnd = DB'($urandom);
            rnd_cycles = $urandom_range(0, OS - 1);
            repeat (rnd_cycles) begin
                @(negedge clock);
                rx_in = 1'b1;
            end
            exp_q.push_back(rnd);
            send_frame(rnd, 1'b1, $urandom_range(0, 2));
        end
        drive_bit(1'b1);
        drive_bit(1'b1);
        check("loop_valid_cnt", valid_cnt - v0, 32'd20);
        check("loop_error_cnt", error_cnt - e0, 32'd0);
        check("loop_busy", {31'd0, busy}, 32'd0);

        check("exp_q_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
